// File: rtl/vga_pkg.sv
// Shared VGA timing types, the stock 640x480@60 mode and raster total helpers.
package vga_pkg;

  typedef struct packed {
    logic [15:0] h_active, h_fp, h_sync, h_bp;
    logic [15:0] v_active, v_fp, v_sync, v_bp;
    logic        h_pol, v_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640x480_60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
    h_pol: 1'b0, v_pol: 1'b0
  };

  typedef struct packed {
    logic [3:0] r, g, b;
  } rgb444_t;

  // hs/vs are carried as "asserted" flags; polarity is applied at the pins
  typedef struct packed {
    logic de, hs, vs;
  } vga_ctl_t;

  function automatic int h_total(vga_timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int v_total(vga_timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with synchronous clear; DEPTH=0 is a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_thru
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, clr, ce};
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr;
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        sr <= '0;
      end else if (ce) begin
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end
    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster engine: pixel-tick divider, h/v counters, pixel request and
// pipeline-aligned sync/colour pin registers.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = int'(VGA_640x480_60.h_active),
  parameter int H_FP     = int'(VGA_640x480_60.h_fp),
  parameter int H_SYNC   = int'(VGA_640x480_60.h_sync),
  parameter int H_BP     = int'(VGA_640x480_60.h_bp),
  parameter int V_ACTIVE = int'(VGA_640x480_60.v_active),
  parameter int V_FP     = int'(VGA_640x480_60.v_fp),
  parameter int V_SYNC   = int'(VGA_640x480_60.v_sync),
  parameter int V_BP     = int'(VGA_640x480_60.v_bp),
  parameter bit H_POL    = VGA_640x480_60.h_pol,
  parameter bit V_POL    = VGA_640x480_60.v_pol,
  parameter int PIPE     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] rgb_in,
  output logic        pix_ce,
  output logic        req,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic        Hsync,
  output logic        Vsync,
  output logic [3:0]  vgaRed,
  output logic [3:0]  vgaGreen,
  output logic [3:0]  vgaBlue
);

  localparam vga_timing_t TM = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP),
    h_pol: H_POL, v_pol: V_POL
  };
  localparam int H_TOTAL = h_total(TM);
  localparam int V_TOTAL = v_total(TM);
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] HA    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS0   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS1   = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [XW-1:0] HLAST = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] VA    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS0   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS1   = YW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [YW-1:0] VLAST = YW'(V_TOTAL - 1);

  logic [DW-1:0] div;
  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  vga_ctl_t      ctl, ctl_q;
  rgb444_t       pix;

  // rst gates the tick so CLK_DIV=1 does not strobe while held in reset
  assign pix_ce      = (div == DLAST) && en && !rst;
  assign req         = (hcnt < HA) && (vcnt < VA);
  assign x           = hcnt;
  assign y           = vcnt;
  assign line_start  = pix_ce && (hcnt == '0);
  assign frame_start = line_start && (vcnt == '0);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div  <= '0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      div <= (div == DLAST) ? '0 : div + 1'b1;
      if (pix_ce) begin
        if (hcnt == HLAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == VLAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  assign ctl.de = req;
  assign ctl.hs = (hcnt >= HS0) && (hcnt <= HS1);
  assign ctl.vs = (vcnt >= VS0) && (vcnt <= VS1);

  vga_delay_line #(.WIDTH($bits(vga_ctl_t)), .DEPTH(PIPE - 1)) u_dly (
    .clk (clk),
    .rst (rst),
    .clr (!en),
    .ce  (pix_ce),
    .d   (ctl),
    .q   (ctl_q)
  );

  // Blanking is enforced here: rgb_in only reaches the pins inside the visible area
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      Hsync <= ~H_POL;
      Vsync <= ~V_POL;
      pix   <= '0;
    end else if (pix_ce) begin
      Hsync <= ctl_q.hs ? H_POL : ~H_POL;
      Vsync <= ctl_q.vs ? V_POL : ~V_POL;
      pix   <= ctl_q.de ? rgb444_t'(rgb_in) : '0;
    end
  end

  assign vgaRed   = pix.r;
  assign vgaGreen = pix.g;
  assign vgaBlue  = pix.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny-raster instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic        rst_d, en_d, pce_d, req_d, ls_d, fs_d, hs_d, vs_d;
  logic [11:0] rgb_d;
  logic [9:0]  x_d, y_d;
  logic [3:0]  r_d, g_d, b_d;

  // small-raster instance
  logic        rst_s, en_s, pce_s, req_s, ls_s, fs_s, hs_s, vs_s;
  logic [11:0] rgb_s;
  logic [2:0]  x_s, y_s;
  logic [3:0]  r_s, g_s, b_s;

  vga_timing_gen u_dut (
    .clk(clk), .rst(rst_d), .en(en_d), .rgb_in(rgb_d),
    .pix_ce(pce_d), .req(req_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d), .Hsync(hs_d), .Vsync(vs_d),
    .vgaRed(r_d), .vgaGreen(g_d), .vgaBlue(b_d)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .PIPE(1)
  ) u_small (
    .clk(clk), .rst(rst_s), .en(en_s), .rgb_in(rgb_s),
    .pix_ce(pce_s), .req(req_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s), .Hsync(hs_s), .Vsync(vs_s),
    .vgaRed(r_s), .vgaGreen(g_s), .vgaBlue(b_s)
  );

  wire [11:0] col_d = {r_d, g_d, b_d};
  wire [11:0] col_s = {r_s, g_s, b_s};

  int n_chk  = 0;
  int n_fail = 0;
  int mode   = 0;

  typedef struct {
    int          k;
    int          x, y;
    logic        hs, vs;
    logic [11:0] col;
    logic        ls, fs;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req_v);
    n_chk++;
    if (act != req_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, req_v, req_v);
    end
  endtask

  // One clk; in mode 1 acts as a pixel source with one tick of latency
  task automatic step();
    logic        pce;
    logic [11:0] nxt;
    @(negedge clk);
    pce = pce_d;
    nxt = {x_d[3:0], y_d[3:0], 4'h0};
    @(posedge clk);
    #1;
    if (mode == 1 && pce) rgb_d = nxt;
  endtask

  initial begin
    vec_t tbl[13];
    int n, e, w, lo, per, nz, k, fsc, hsc;

    tbl[0]  = '{k:1,  x:1, y:0, hs:1'b0, vs:1'b1, col:12'hA5C, ls:1'b0, fs:1'b0};
    tbl[1]  = '{k:5,  x:5, y:0, hs:1'b0, vs:1'b1, col:12'h000, ls:1'b0, fs:1'b0};
    tbl[2]  = '{k:6,  x:6, y:0, hs:1'b1, vs:1'b1, col:12'h000, ls:1'b0, fs:1'b0};
    tbl[3]  = '{k:7,  x:7, y:0, hs:1'b1, vs:1'b1, col:12'h000, ls:1'b0, fs:1'b0};
    tbl[4]  = '{k:8,  x:0, y:1, hs:1'b0, vs:1'b1, col:12'h000, ls:1'b1, fs:1'b0};
    tbl[5]  = '{k:12, x:4, y:1, hs:1'b0, vs:1'b1, col:12'hA5C, ls:1'b0, fs:1'b0};
    tbl[6]  = '{k:17, x:1, y:2, hs:1'b0, vs:1'b1, col:12'h000, ls:1'b0, fs:1'b0};
    tbl[7]  = '{k:25, x:1, y:3, hs:1'b0, vs:1'b0, col:12'h000, ls:1'b0, fs:1'b0};
    tbl[8]  = '{k:32, x:0, y:4, hs:1'b0, vs:1'b0, col:12'h000, ls:1'b1, fs:1'b0};
    tbl[9]  = '{k:33, x:1, y:4, hs:1'b0, vs:1'b1, col:12'h000, ls:1'b0, fs:1'b0};
    tbl[10] = '{k:39, x:7, y:4, hs:1'b1, vs:1'b1, col:12'h000, ls:1'b0, fs:1'b0};
    tbl[11] = '{k:40, x:0, y:0, hs:1'b0, vs:1'b1, col:12'h000, ls:1'b1, fs:1'b1};
    tbl[12] = '{k:41, x:1, y:0, hs:1'b0, vs:1'b1, col:12'hA5C, ls:1'b0, fs:1'b0};

    rst_d = 1'b1; en_d = 1'b1; rgb_d = 12'hFFF;
    rst_s = 1'b1; en_s = 1'b1; rgb_s = 12'hA5C;
    @(posedge clk); #1;
    repeat (3) step();

    chk("rst_hsync", hs_d, 1);
    chk("rst_vsync", vs_d, 1);
    chk("rst_colour", col_d, 0);
    chk("rst_pix_ce", pce_d, 0);
    chk("rst_x", x_d, 0);
    chk("rst_y", y_d, 0);
    chk("rst_frame_start", fs_d, 0);
    chk("rst_small_hsync", hs_s, 0);
    chk("rst_small_pix_ce", pce_s, 0);

    rst_d = 1'b0;
    n = 0;
    while (!pce_d && n < 20) begin step(); n++; end
    chk("first_pix_ce_edge", n + 1, 4);
    chk("first_frame_start", fs_d, 1);

    e = n;
    while (col_d == 12'h0 && e < 40) begin step(); e++; end
    chk("first_colour_edge", e, 8);
    chk("first_colour_value", col_d, 12'hFFF);

    n = 0;
    while (!pce_d && n < 20) begin step(); n++; end
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin step(); n++; end while (!pce_d && n < 20);
      chk("pix_ce_period", n, 4);
    end

    w = 0;
    while (hs_d && w < 4000) begin step(); w++; end
    chk("hsync_fall_found", hs_d, 0);
    lo = 0; nz = 0;
    while (!hs_d && lo < 5000) begin if (col_d != 12'h0) nz++; step(); lo++; end
    chk("hsync_low_clks", lo, 384);
    per = lo;
    while (hs_d && per < 8000) begin if (col_d != 12'h0) nz++; step(); per++; end
    chk("line_period_clks", per, 3200);
    chk("visible_clks_per_line", nz, 2560);

    mode = 1;
    w = 0;
    while (!(x_d == 10'd6 && y_d == 10'd3) && w < 20000) begin step(); w++; end
    chk("reach_6_3", x_d, 6);
    n = 0;
    while (!pce_d && n < 20) begin step(); n++; end
    step();
    chk("pixel_5_3", col_d, 12'h530);
    repeat (4) step();
    chk("pixel_6_3", col_d, 12'h630);

    w = 0;
    while (x_d != 10'd300 && w < 4000) begin step(); w++; end
    chk("reach_x300_colour", (col_d != 12'h0) ? 1 : 0, 1);
    en_d = 1'b0;
    step();
    chk("en_low_x", x_d, 0);
    chk("en_low_y", y_d, 0);
    chk("en_low_hsync", hs_d, 1);
    chk("en_low_vsync", vs_d, 1);
    chk("en_low_colour", col_d, 0);
    repeat (5) step();
    chk("en_low_pix_ce", pce_d, 0);
    chk("en_low_x_hold", x_d, 0);
    en_d = 1'b1;
    n = 0;
    while (!pce_d && n < 20) begin step(); n++; end
    chk("reen_pix_ce_edge", n + 1, 4);
    chk("reen_frame_start", fs_d, 1);

    rst_s = 1'b0;
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin step(); k++; end
      chk($sformatf("small_k%0d_x", tbl[i].k), x_s, tbl[i].x);
      chk($sformatf("small_k%0d_y", tbl[i].k), y_s, tbl[i].y);
      chk($sformatf("small_k%0d_hsync", tbl[i].k), hs_s, tbl[i].hs);
      chk($sformatf("small_k%0d_vsync", tbl[i].k), vs_s, tbl[i].vs);
      chk($sformatf("small_k%0d_colour", tbl[i].k), col_s, tbl[i].col);
      chk($sformatf("small_k%0d_line_start", tbl[i].k), ls_s, tbl[i].ls);
      chk($sformatf("small_k%0d_frame_start", tbl[i].k), fs_s, tbl[i].fs);
    end

    fsc = 0; hsc = 0;
    repeat (80) begin
      step();
      if (fs_s) fsc++;
      if (hs_s) hsc++;
    end
    chk("small_frame_starts_80clk", fsc, 2);
    chk("small_hsync_high_80clk", hsc, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster engine that replaces fixed 640x480 sync logic in the Basys3 VGA top level. It generates the pixel-clock enable from the 100 MHz system clock and maintains the horizontal and vertical counters. It issues a pixel request with (x, y) a configurable number of pixel ticks ahead of the pins, then drives `Hsync`, `Vsync`, `vgaRed`, `vgaGreen` and `vgaBlue` with sync, blanking and returned pixel data aligned. It sits between the frame-buffer/pattern source and the VGA connector pins.

## Interface
- `CLK_DIV`, 4, system clocks per pixel tick (≥1; 4 gives 25 MHz from 100 MHz)
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths in pixels
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths in lines
- `H_POL` / `V_POL`, 0 / 0, asserted sync level (0 = active-low)
- `PIPE`, 2, pixel-tick latency from request to pins (≥1)
- `clk`  in  1  system clock (100 MHz)
- `rst`  in  1  synchronous, active-high reset; driven from `btnC` at top level
- `en`  in  1  run enable; low acts as a soft reset
- `rgb_in`  in  12  {R,G,B} 4:4:4 pixel data, sampled `PIPE` ticks after `req`
- `pix_ce`  out  1  one-clk pixel tick strobe
- `req`  out  1  counter position is in the visible area
- `x`  out  $clog2(H_TOTAL)  current hcnt
- `y`  out  $clog2(V_TOTAL)  current vcnt
- `line_start` / `frame_start`  out  1  one-clk pulses at counter level
- `Hsync`, `Vsync`  out  1  pin-level syncs
- `vgaRed`, `vgaGreen`, `vgaBlue`  out  4 each  pin-level colour

## Operation
- `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800). `V_TOTAL` is defined the same way (525).
- Divider `div` runs 0..CLK_DIV-1. `pix_ce = (div == CLK_DIV-1) && en`. With `CLK_DIV=1`, `pix_ce = en`.
- On `pix_ce`, `hcnt` increments. At `H_TOTAL-1`, `hcnt` wraps to 0 and `vcnt` increments. `vcnt` wraps at `V_TOTAL-1`.
- `req = hcnt < H_ACTIVE && vcnt < V_ACTIVE` (combinational). `x = hcnt`, `y = vcnt`.
- Raw horizontal sync is asserted for `hcnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]`. Vertical sync is defined the same way on `vcnt`. Asserted level is `H_POL` / `V_POL`.
- `line_start = pix_ce && hcnt==0`. `frame_start = line_start && vcnt==0`.
- A delay line of `PIPE-1` stages, advancing only on `pix_ce`, carries {de=req, hs, vs}.
- The output register updates on `pix_ce` from the last stage:
  - `Hsync` / `Vsync` take the delayed values.
  - Colour takes `rgb_in` when delayed de=1, else 0.
- Blanking is enforced here. `rgb_in` is ignored outside the visible area.
- `en` low (synchronous): `div`, `hcnt`, `vcnt` and delay line clear, syncs drive their inactive level, colour is 0. These take effect on the next edge.
- `en` rising: the first `pix_ce` occurs CLK_DIV clks later, with `frame_start` at (0,0).
- `rst` overrides `en`. Reset mid-line or mid-frame restarts at (0,0) with no partial sync pulse held over.

## Timing
- Reset values: `div=0`, `hcnt=vcnt=0`, `pix_ce=0`, `line_start=frame_start=0`, `Hsync=~H_POL`, `Vsync=~V_POL`, colour 0, delay line all de=0 with hs/vs deasserted.
- First `pix_ce` after `rst` release occurs CLK_DIV clks later (clk edge CLK_DIV counted from 1).
- Latency: a counter position reaches the pins `PIPE` pixel ticks after it is presented. Pins change 1 clk after the `pix_ce` edge and hold for CLK_DIV clks.
- Hsync pulse width is `H_SYNC*CLK_DIV` clks; line period is `H_TOTAL*CLK_DIV` clks.
- Vsync transitions coincide with an Hsync-period boundary, delayed by the same `PIPE`.
- Horizontal and vertical wrap on the same tick: `hcnt`→0 and `vcnt`→0 together, and `frame_start` fires on the following tick.

## Structure
- `vga_pkg`:
  - `vga_timing_t` struct (active/fp/sync/bp per axis, polarity)
  - `VGA_640x480_60` constant
  - `rgb444_t` typedef (4-bit r, g, b)
  - `h_total()` / `v_total()` functions
- One sub-module, `vga_delay_line`, holds WIDTH and DEPTH parameters, an enable-gated shift register, and a synchronous clear. It is instantiated for {de, hs, vs}.

## Test plan
- `rst`=1 for 3 clks, `en`=1 → `Hsync`=`Vsync`=1, colour 0, `pix_ce` 0, `x`=`y`=0; first `pix_ce` on the 4th clk after release.
- Default parameters: `pix_ce` period is 4 clks. `Hsync` is low for exactly 384 clks and repeats every 3200 clks. `Vsync` is low for 6400 clks every 1,680,000 clks. `frame_start` fires exactly once per frame.
- `PIPE=2`, `rgb_in`=12'hFFF constant → colour is 12'hFFF only in the 640 visible ticks per line, first appearing 2 ticks after `req` rises at (0,0). Colour is 0 in all porches and sync.
- `rgb_in` = {x[3:0], y[3:0], 4'h0} → the pin pixel at visible position (5,3) equals 12'h530 (the value for `x`=5, `y`=3).
- `en` dropped at `hcnt`=300 → next clk `x`=0, `Hsync`=1, colour 0. On re-raise, `frame_start` coincides with the first `pix_ce`, 4 clks later.
- Small config: H=4/1/2/1, V=2/1/1/1, `H_POL`=1, `CLK_DIV`=1, `PIPE`=1:
  - `Hsync` is high for 2 of every 8 clks.
  - `hcnt` and `vcnt` wrap together at (7,4).
  - `frame_start` fires every 40 clks.
